// File: rtl/alu_share_pkg.sv
// Shared types and opcode constants for the two-requester add/sub sequencer.
// Optional feature macro used by alu_share_ctrl: ALU_SHARE_STICKY_OVF_EN.
package alu_share_pkg;

   localparam int N = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [1:0] REQ_OP_RSVD = 2'b00;
   localparam logic [1:0] REQ_OP_SADD = 2'b01;
   localparam logic [1:0] REQ_OP_UADD = 2'b10;
   localparam logic [1:0] REQ_OP_SUB  = 2'b11;

   localparam logic [4:0] DP_OP_NOP  = 5'b00000;
   localparam logic [4:0] DP_OP_SADD = 5'b00001;
   localparam logic [4:0] DP_OP_UADD = 5'b00010;
   localparam logic [4:0] DP_OP_SUB  = 5'b00011;

   typedef struct packed {
      logic       err;
      logic [4:0] aluop;
   } op_map_t;

   // Reserved request opcode drives a NOP onto the datapath and flags an error.
   function automatic op_map_t map_op(input logic [1:0] op);
      op_map_t m;
      m.err   = 1'b0;
      m.aluop = DP_OP_NOP;
      case (op)
         REQ_OP_SADD: m.aluop = DP_OP_SADD;
         REQ_OP_UADD: m.aluop = DP_OP_UADD;
         REQ_OP_SUB:  m.aluop = DP_OP_SUB;
         default:     m.err   = 1'b1;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, registered
// last-grant pointer that starts at 1 so requester 0 wins the first tie.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] valid,
   input  logic       update,
   output logic [1:0] grant
);

   logic last_reg;

   always_comb begin
      grant = valid;
      if (valid == 2'b11) begin
         grant = last_reg ? 2'b01 : 2'b10;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_reg <= 1'b1;
      end else if (update && (grant != 2'b00)) begin
         last_reg <= grant[1];
      end
   end

endmodule

// File: rtl/alu_share_ctrl.sv
// Sequencer sharing one add/sub datapath between two valid/ready requesters.
// Define ALU_SHARE_STICKY_OVF_EN to enable the sticky overflow flag.
module alu_share_ctrl
   import alu_share_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [1:0]   req0_op,
   input  logic [N-1:0] req0_a,
   input  logic [N-1:0] req0_b,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [1:0]   req1_op,
   input  logic [N-1:0] req1_a,
   input  logic [N-1:0] req1_b,
   output logic [N-1:0] dp_a,
   output logic [N-1:0] dp_b,
   output logic [4:0]   dp_aluop,
   input  logic [N-1:0] dp_sum,
   input  logic         dp_cout,
   input  logic         dp_neg,
   input  logic         dp_ovf,
   input  logic         dp_zero,
   output logic         resp_valid,
   input  logic         resp_ready,
   output logic         resp_id,
   output logic [N-1:0] resp_result,
   output logic         resp_cout,
   output logic         resp_neg,
   output logic         resp_ovf,
   output logic         resp_zero,
   output logic         resp_err,
   output logic         busy,
   output logic         sticky_ovf,
   input  logic         sticky_clr
);

   state_t         state_reg, state_next;
   logic [1:0]     req_valid, grant, req_ready;
   logic           grant_en, sel;
   logic [1:0]     op_sel;
   logic [N-1:0]   a_sel, b_sel;
   op_map_t        map_sel;

   logic [N-1:0]   dp_a_reg, dp_b_reg, resp_result_reg;
   logic [4:0]     dp_aluop_reg;
   logic           id_reg, err_reg;
   logic           resp_id_reg, resp_err_reg;
   logic           resp_cout_reg, resp_neg_reg, resp_ovf_reg, resp_zero_reg;

   assign req_valid = {req1_valid, req0_valid};
   assign grant_en  = (state_reg == IDLE);

   rr_arb2 u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .valid  (req_valid),
      .update (grant_en),
      .grant  (grant)
   );

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_ready
         assign req_ready[gi] = grant_en & grant[gi];
      end
   endgenerate

   assign req0_ready = req_ready[0];
   assign req1_ready = req_ready[1];

   assign sel     = grant[1];
   assign op_sel  = sel ? req1_op : req0_op;
   assign a_sel   = sel ? req1_a  : req0_a;
   assign b_sel   = sel ? req1_b  : req0_b;
   assign map_sel = map_op(op_sel);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (req_valid != 2'b00) state_next = EXEC;
         EXEC:    state_next = RESP;
         RESP:    if (resp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Operands are sampled only on the grant edge; they hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dp_a_reg     <= '0;
         dp_b_reg     <= '0;
         dp_aluop_reg <= DP_OP_NOP;
         id_reg       <= 1'b0;
         err_reg      <= 1'b0;
      end else if (req_ready != 2'b00) begin
         dp_a_reg     <= a_sel;
         dp_b_reg     <= b_sel;
         dp_aluop_reg <= map_sel.aluop;
         id_reg       <= sel;
         err_reg      <= map_sel.err;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_result_reg <= '0;
         resp_cout_reg   <= 1'b0;
         resp_neg_reg    <= 1'b0;
         resp_ovf_reg    <= 1'b0;
         resp_zero_reg   <= 1'b0;
         resp_id_reg     <= 1'b0;
         resp_err_reg    <= 1'b0;
      end else if (state_reg == EXEC) begin
         resp_result_reg <= err_reg ? '0 : dp_sum;
         resp_cout_reg   <= ~err_reg & dp_cout;
         resp_neg_reg    <= ~err_reg & dp_neg;
         resp_ovf_reg    <= ~err_reg & dp_ovf;
         resp_zero_reg   <= ~err_reg & dp_zero;
         resp_id_reg     <= id_reg;
         resp_err_reg    <= err_reg;
      end
   end

`ifdef ALU_SHARE_STICKY_OVF_EN
   logic sticky_ovf_reg;

   // Set takes priority over a same-edge clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_ovf_reg <= 1'b0;
      end else if ((state_reg == EXEC) && !err_reg && dp_ovf) begin
         sticky_ovf_reg <= 1'b1;
      end else if (sticky_clr) begin
         sticky_ovf_reg <= 1'b0;
      end
   end

   assign sticky_ovf = sticky_ovf_reg;
`else
   logic unused_sticky_clr;
   assign unused_sticky_clr = sticky_clr;
   assign sticky_ovf        = 1'b0;
`endif

   assign dp_a        = dp_a_reg;
   assign dp_b        = dp_b_reg;
   assign dp_aluop    = dp_aluop_reg;
   assign resp_valid  = (state_reg == RESP);
   assign resp_id     = resp_id_reg;
   assign resp_result = resp_result_reg;
   assign resp_cout   = resp_cout_reg;
   assign resp_neg    = resp_neg_reg;
   assign resp_ovf    = resp_ovf_reg;
   assign resp_zero   = resp_zero_reg;
   assign resp_err    = resp_err_reg;
   assign busy        = (state_reg != IDLE);

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Two-requester sequencer for the shared 32-bit carry-select add/sub datapath. Arbitrates round-robin between two valid/ready request ports, registers the winner's operands and opcode onto the datapath, and captures result and flags one cycle later. Returns them on a single tagged valid/ready response port. Sits between issue logic and the combinational adder, so the datapath always sees stable inputs for a full cycle.

## Interface
- N, 32, operand/result width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_op / req1_op  in  2  01 signed add, 10 unsigned add, 11 subtract, 00 reserved
- req0_a, req0_b / req1_a, req1_b  in  N  operands
- dp_a, dp_b  out  N  registered operands to datapath
- dp_aluop  out  5  registered datapath opcode
- dp_sum  in  N  datapath result
- dp_cout, dp_neg, dp_ovf, dp_zero  in  1  datapath carry/flags
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_id  out  1  requester index of response
- resp_result  out  N  captured result
- resp_cout, resp_neg, resp_ovf, resp_zero  out  1  captured flags
- resp_err  out  1  reserved opcode was issued
- busy  out  1  state != IDLE
- sticky_ovf  out  1  accumulated overflow (see Configuration)
- sticky_clr  in  1  clears sticky_ovf

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - No valid request: stay.
  - Otherwise grant one requester: assert its reqX_ready combinationally, load dp_a/dp_b/dp_aluop and internal id/err, go EXEC.
- Round-robin: only one valid → grant it. Both valid → grant the requester not granted last. The last-grant pointer resets to 1, so requester 0 wins the first tie.
- Opcode map to dp_aluop: 01→00001, 10→00010, 11→00011, 00→00000 with err=1.
- EXEC: at the clock edge, capture dp_sum and dp_* flags into the resp_* registers and go RESP.
  - If err=1, capture result 0 and all flags 0 instead.
- RESP:
  - resp_valid=1; all resp_* held stable.
  - On resp_valid & resp_ready, go IDLE.
  - No request is accepted while in EXEC or RESP; reqX_ready=0.
- dp_* outputs hold their last value outside EXEC.

## Timing
- Reset values: state IDLE; reqX_ready 0; resp_valid 0; all resp_* 0; dp_a, dp_b, dp_aluop 0; busy 0; sticky_ovf 0; last-grant pointer 1.
- Latency: request accepted at edge T → resp_valid high from T+2.
- Minimum interval between accepts: 3 cycles with resp_ready tied high.
- Backpressure: resp_ready low holds RESP indefinitely. Requesters see ready=0 throughout.
- A request dropped (valid deasserted) before its ready is simply not taken. Operands are sampled only on the grant edge.
- Asserting rst_n low in any state:
  - Returns to IDLE immediately.
  - The in-flight operation is discarded and no response is produced.

## Configuration
- ALU_SHARE_STICKY_OVF_EN defined:
  - sticky_ovf is set on the RESP-entry edge when the captured ovf=1.
  - sticky_ovf is cleared by sticky_clr.
  - Simultaneous set and clear: set wins.
- ALU_SHARE_STICKY_OVF_EN undefined: sticky_ovf is constant 0, sticky_clr is ignored, and both ports remain.

## Structure
- Shared package alu_share_pkg holds:
  - state enum (IDLE/EXEC/RESP)
  - 2-bit request opcode constants
  - 5-bit datapath opcode constants
  - the opcode-mapping function
- Sub-module rr_arb2: combinational 2-way round-robin grant plus the registered last-grant pointer. Its inputs are the two valids and an update strobe; its output is a one-hot grant.
- The datapath is not instantiated. It connects externally through the dp_* ports.

## Test plan
- Reset, then req0 op=01 a=5 b=7 → req0_ready at T, resp_valid at T+2, dp_aluop=00001, resp_result=dp_sum, resp_id=0, busy high T+1..RESP exit.
- Both valid continuously with resp_ready=1 → grants alternate 0,1,0,1, every 3 cycles.
- req1 op=11 with resp_ready low for 5 cycles → response held stable 5 cycles; req0 valid throughout sees ready=0; req0 granted in the cycle after the handshake.
- req0 op=00 → dp_aluop=00000, resp_err=1, resp_result=0, all flags 0.
- rst_n pulsed low during EXEC → no resp_valid; state IDLE; next tie grants requester 0.
- With ALU_SHARE_STICKY_OVF_EN, dp_ovf=1 in EXEC → sticky_ovf=1 after RESP entry; sticky_clr and an ovf capture on the same edge → remains 1. Without the macro, sticky_ovf stays 0.
